// File: rtl/press_classifier.sv
// Classifies debounced switch gestures into short, long and double presses.
// Emits a one-cycle registered pulse per gesture; o_Busy flags an in-flight gesture.
module press_classifier #(
  parameter int unsigned LONG_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES  = 12_500_000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Short_Press,
  output logic o_Long_Press,
  output logic o_Double_Press,
  output logic o_Busy
);

  localparam int unsigned MAX_CYCLES = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HELD1     = 3'd1,
    ST_LONG_WAIT = 3'd2,
    ST_GAP       = 3'd3,
    ST_HELD2     = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             switch_q;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             double_q, double_d;
  logic             busy_q;
  logic             rise_c;

  assign rise_c = i_Switch & ~switch_q;

  // State, counter, edge register and registered pulses
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      switch_q <= 1'b0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      switch_q <= i_Switch;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
      busy_q   <= (state_d != ST_IDLE);
    end
  end

  // Next-state logic; counter clears on every transition and only advances while dwelling
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rise_c) begin
          state_d = ST_HELD1;
          cnt_d   = '0;
        end
      end
      ST_HELD1: begin
        // Release on the limit cycle takes priority over the long classification
        if (!i_Switch) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          state_d = ST_LONG_WAIT;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LONG_WAIT: begin
        if (!i_Switch) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_GAP: begin
        // A second press on the limit cycle still counts as a double
        if (rise_c) begin
          state_d = ST_HELD2;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          short_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HELD2: begin
        if (!i_Switch) begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          double_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign o_Short_Press  = short_q;
  assign o_Long_Press   = long_q;
  assign o_Double_Press = double_q;
  assign o_Busy         = busy_q;

endmodule

// File: tb/tb_press_classifier.sv
// Scoreboard bench for press_classifier: expected pulses (kind, edge index, busy)
// are queued as gestures are driven and matched when the DUT pulses.
module tb_press_classifier;

  localparam int unsigned LONG_CYCLES = 8;
  localparam int unsigned GAP_CYCLES  = 4;

  localparam logic [2:0] K_SHORT  = 3'b001;
  localparam logic [2:0] K_LONG   = 3'b010;
  localparam logic [2:0] K_DOUBLE = 3'b100;

  typedef struct {
    logic [2:0] kind;
    int         edge_n;
    logic       busy;
  } exp_t;

  logic clk;
  logic rst_n;
  logic sw;
  logic short_p, long_p, double_p, busy;

  exp_t sb[$];
  int   edge_cnt;
  int   n_vec;
  int   n_err;

  press_classifier #(
    .LONG_CYCLES(LONG_CYCLES),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .i_Clk         (clk),
    .i_Rst_L       (rst_n),
    .i_Switch      (sw),
    .o_Short_Press (short_p),
    .o_Long_Press  (long_p),
    .o_Double_Press(double_p),
    .o_Busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, edge_cnt);
    end
  endtask

  // Drive sw for n edges; first_edge is the index of the first edge sampling it
  task automatic drive(input logic v, input int n, output int first_edge);
    first_edge = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sw = v;
      if (i == 0) first_edge = edge_cnt + 1;
    end
  endtask

  task automatic push(input logic [2:0] kind, input int e, input logic b);
    exp_t x;
    x.kind   = kind;
    x.edge_n = e;
    x.busy   = b;
    sb.push_back(x);
  endtask

  // Match every observed pulse against the scoreboard head
  always @(negedge clk) begin
    logic [2:0] seen;
    exp_t       x;
    seen = {double_p, long_p, short_p};
    if (seen != 3'b000) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'(seen), 32'd0);
      end else begin
        x = sb.pop_front();
        check("pulse_kind", 32'(seen), 32'(x.kind));
        check("pulse_edge", 32'(edge_cnt), 32'(x.edge_n));
        check("busy_at_pulse", 32'(busy), 32'(x.busy));
      end
    end
  end

  initial begin
    int r, f, r2, f2, d;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    sw    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_short", 32'(short_p), 32'd0);
    check("rst_long", 32'(long_p), 32'd0);
    check("rst_double", 32'(double_p), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    drive(1'b0, 3, d);

    // Short press: high 3, low; short at release edge + GAP
    drive(1'b1, 3, r);
    check("short_busy_hold", 32'(busy), 32'd1);
    drive(1'b0, 1, f);
    push(K_SHORT, f + GAP_CYCLES, 1'b0);
    drive(1'b0, 10, d);
    check("short_busy_end", 32'(busy), 32'd0);

    // Long press: held 20; long at R + LONG, silent release
    drive(1'b1, 1, r);
    push(K_LONG, r + LONG_CYCLES, 1'b1);
    drive(1'b1, 19, d);
    check("long_busy_wait", 32'(busy), 32'd1);
    drive(1'b0, 1, f);
    @(posedge clk);
    #1;
    check("long_busy_end", 32'(busy), 32'd0);
    drive(1'b0, 8, d);

    // Double press: high 2, low 2, high 2, low
    drive(1'b1, 2, r);
    drive(1'b0, 2, f);
    drive(1'b1, 2, r2);
    drive(1'b0, 1, f2);
    push(K_DOUBLE, f2, 1'b0);
    drive(1'b0, 10, d);

    // Release exactly on the long limit edge -> short, no long
    drive(1'b1, LONG_CYCLES, r);
    drive(1'b0, 1, f);
    check("limit_rel_edge", 32'(f), 32'(r + LONG_CYCLES));
    push(K_SHORT, f + GAP_CYCLES, 1'b0);
    drive(1'b0, 10, d);

    // Second rise exactly on the gap limit edge -> double, no short
    drive(1'b1, 2, r);
    drive(1'b0, GAP_CYCLES, f);
    drive(1'b1, 2, r2);
    check("limit_rise_edge", 32'(r2), 32'(f + GAP_CYCLES));
    drive(1'b0, 1, f2);
    push(K_DOUBLE, f2, 1'b0);
    drive(1'b0, 10, d);

    // Reset mid-gesture at count 5 aborts with no pulse
    drive(1'b1, 6, r);
    @(posedge clk);
    #2;
    check("midrst_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_pulses", 32'({double_p, long_p, short_p}), 32'd0);
    @(negedge clk);
    sw = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 20, d);
    check("midrst_sb_empty", 32'(sb.size()), 32'd0);

    // Reset released while pressed: first edge is a rise, long after 8
    @(negedge clk);
    rst_n = 1'b0;
    sw    = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    r = edge_cnt + 1;
    push(K_LONG, r + LONG_CYCLES, 1'b1);
    drive(1'b1, 10, d);
    drive(1'b0, 10, d);
    check("final_busy", 32'(busy), 32'd0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/press_classifier.md
# press_classifier

Consumes the debounced, active-high switch level produced by the debounce stage and classifies each user gesture as a short press, long press or double press. Emits a one-cycle pulse per classified gesture for downstream LED/mode logic, replacing raw release-edge toggling. Pure single-clock sequential block: input edge register, one cycle counter, five-state FSM.

## Interface
- LONG_CYCLES, 25_000_000: hold duration in clocks that qualifies a long press (0.5 s at 50 MHz); legal range ≥ 2.
- GAP_CYCLES, 12_500_000: maximum release-to-second-press gap in clocks for a double press (0.25 s at 50 MHz); legal range ≥ 2.
- i_Clk  input  1  system clock; all state updates on rising edge.
- i_Rst_L  input  1  reset, asynchronous assert, active-low.
- i_Switch  input  1  debounced switch level, 1 = pressed; synchronous to i_Clk.
- o_Short_Press  output  1  one-cycle pulse: single press released before LONG_CYCLES, with no second press within GAP_CYCLES.
- o_Long_Press  output  1  one-cycle pulse: press held for LONG_CYCLES.
- o_Double_Press  output  1  one-cycle pulse: second press and its release completed.
- o_Busy  output  1  1 while FSM is not IDLE.

## Operation
- r_Switch registers i_Switch every clock. rise = i_Switch & ~r_Switch; fall = ~i_Switch & r_Switch.
- Counter width = $clog2(max(LONG_CYCLES, GAP_CYCLES)); cleared on every state entry; increments by 1 per clock while in HELD1 or GAP; never wraps (limit compare exits first).
- States and transitions (evaluated each rising edge):
  - IDLE: rise -> HELD1, count = 0. Otherwise stay.
  - HELD1: i_Switch = 0 -> GAP, count = 0. Else if count == LONG_CYCLES-1 -> assert o_Long_Press, go LONG_WAIT. Else count++.
  - LONG_WAIT: i_Switch = 0 -> IDLE. No pulses emitted; the release is silent.
  - GAP: rise -> HELD2. Else if count == GAP_CYCLES-1 -> assert o_Short_Press, go IDLE. Else count++.
  - HELD2: i_Switch = 0 -> assert o_Double_Press, go IDLE. No long-press classification in HELD2, regardless of hold length.
- Simultaneous events: in HELD1, release on the limit cycle -> release wins (GAP, no long). In GAP, rise on the limit cycle -> rise wins (HELD2, no short).
- At most one output pulse per clock; the three pulse outputs are mutually exclusive.
- Illegal/unused state encodings return to IDLE on the next edge with no pulse.

## Timing
- Reset (i_Rst_L = 0, asynchronous): state = IDLE, count = 0, r_Switch = 0, o_Short_Press = o_Long_Press = o_Double_Press = 0, o_Busy = 0. Reset mid-gesture aborts it with no pulse.
- Switch already pressed when reset deasserts: r_Switch = 0, so the first edge sees a rise and starts HELD1 (treated as a new press).
- Pulse outputs are registered; each is high for exactly one clock. o_Busy is decoded from the state register.
- Let edge R be the edge sampling the rise (i_Switch = 1, r_Switch = 0).
- Long: with i_Switch = 1 at edges R..R+LONG_CYCLES, o_Long_Press is high in the cycle after edge R+LONG_CYCLES.
- Let edge F be the edge sampling the release in HELD1.
- Short: with i_Switch = 0 at edges F..F+GAP_CYCLES, o_Short_Press is high in the cycle after edge F+GAP_CYCLES.
- Double: second rise sampled at edge F+1..F+GAP_CYCLES enters HELD2. o_Double_Press is high in the cycle after the edge that samples the second release.
- o_Busy rises after edge R and falls after the edge that returns the FSM to IDLE, i.e. coincident with the pulse cycle.

## Test plan
Bench parameters: LONG_CYCLES = 8, GAP_CYCLES = 4.
- Short press: i_Switch high 3 clocks then low -> o_Short_Press one-cycle pulse 4 clocks after the release edge; other pulses stay 0; o_Busy then 0.
- Long press: i_Switch high 20 clocks -> o_Long_Press pulse after edge R+8; no pulse on release; o_Busy low after the release edge.
- Double press: high 2, low 2, high 2, low -> single o_Double_Press pulse after the second release edge; no o_Short_Press.
- Boundary collisions: release exactly on the HELD1 limit edge -> GAP, later short (no long). Rise exactly at GAP limit edge F+4 -> double (no short).
- Reset mid-gesture: assert i_Rst_L = 0 during HELD1 (count = 5) -> all outputs 0 immediately. Release reset with switch low -> no pulse ever.
- Reset release while pressed: i_Switch = 1 through reset, hold 10 clocks after -> o_Long_Press pulse 8 clocks after the first edge.
